// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - UART-fed instruction memory that holds the cpu until a verified image is resident
module boot_loader #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          ADDR_W      = 8,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] rom_address,
  output logic [31:0] rom_data,
  output logic        cpu_enable,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam logic [15:0] MAX_WORDS = 16'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    RUN,
    ERROR
  } loaderState;

  loaderState  state;
  loaderState  nextState;

  logic [7:0]  lenLo;
  logic [15:0] lenWords;
  logic [15:0] wrPtr;
  logic [1:0]  byteIdx;
  logic [7:0]  csum;
  logic [23:0] asmWord;
  logic [31:0] mem [DEPTH_WORDS];

  logic [15:0] lenFull;
  logic        lenBad;
  logic        isMagic;
  logic        wordDone;
  logic        lastWord;
  logic        csumOk;

  logic [ADDR_W-1:0] romIndex;
  logic              romHiZero;
  logic              romInRange;
  logic [1:0]        unusedAddrBits;

  // Decode of the incoming byte against the current state
  always_comb begin
    lenFull  = {rx_data, lenLo};
    lenBad   = (lenFull == 16'd0) || (lenFull > MAX_WORDS);
    isMagic  = (rx_data == MAGIC);
    wordDone = (state == PAYLOAD) && rx_valid && (byteIdx == 2'd3);
    lastWord = wordDone && ((wrPtr + 16'd1) == lenWords);
    csumOk   = (rx_data == csum);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic; transitions only on accepted bytes
  always_comb begin
    nextState = state;
    if (rx_valid) begin
      case (state)
        IDLE:    if (isMagic) nextState = LEN_LO;
        LEN_LO:  nextState = LEN_HI;
        LEN_HI:  nextState = lenBad ? ERROR : PAYLOAD;
        PAYLOAD: if (lastWord) nextState = CHECK;
        CHECK:   nextState = csumOk ? RUN : ERROR;
        RUN:     if (isMagic) nextState = LEN_LO;
        ERROR:   if (isMagic) nextState = LEN_LO;
        default: nextState = IDLE;
      endcase
    end
  end

  // Cpu control decoded straight from the state flops, so it is glitch-free
  always_comb begin
    cpu_enable = (state == RUN);
    cpu_reset  = (state != RUN);
  end

  // Length capture, word assembly, write pointer and running checksum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lenLo    <= 8'd0;
      lenWords <= 16'd0;
      wrPtr    <= 16'd0;
      byteIdx  <= 2'd0;
      csum     <= 8'd0;
      asmWord  <= 24'd0;
    end else if (rx_valid) begin
      case (state)
        LEN_LO: lenLo <= rx_data;
        LEN_HI: begin
          lenWords <= lenFull;
          wrPtr    <= 16'd0;
          byteIdx  <= 2'd0;
          csum     <= 8'd0;
        end
        PAYLOAD: begin
          csum    <= csum ^ rx_data;
          byteIdx <= byteIdx + 2'd1;
          case (byteIdx)
            2'd0:    asmWord[7:0]   <= rx_data;
            2'd1:    asmWord[15:8]  <= rx_data;
            2'd2:    asmWord[23:16] <= rx_data;
            default: wrPtr          <= wrPtr + 16'd1;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Image status: set on the checksum verdict, loaded dropped as soon as a reload starts
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaded     <= 1'b0;
      error      <= 1'b0;
      word_count <= 16'd0;
    end else if (rx_valid) begin
      case (state)
        LEN_HI: if (lenBad) error <= 1'b1;
        CHECK: begin
          if (csumOk) begin
            loaded     <= 1'b1;
            error      <= 1'b0;
            word_count <= lenWords;
          end else begin
            loaded     <= 1'b0;
            error      <= 1'b1;
            word_count <= 16'd0;
          end
        end
        RUN: if (isMagic) loaded <= 1'b0;
        default: ;
      endcase
    end
  end

  // Instruction memory write; the fourth byte completes the word in the same edge
  always_ff @(posedge clk) begin
    if (wordDone) begin
      mem[wrPtr[ADDR_W-1:0]] <= {rx_data, asmWord};
    end
  end

  // Fetch port: only the verified, in-range part of the image is visible
  always_comb begin
    romIndex       = rom_address[ADDR_W+1:2];
    romHiZero      = (rom_address[31:ADDR_W+2] == '0);
    romInRange     = ({{(16-ADDR_W){1'b0}}, romIndex} < word_count);
    unusedAddrBits = rom_address[1:0];
    rom_data       = NOP_WORD;
    if (loaded && romHiZero && romInRange) begin
      rom_data = mem[romIndex];
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed vector bench for boot_loader
module tb_boot_loader;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  // flag nibble = {cpu_enable, cpu_reset, loaded, error}
  localparam logic [3:0]  HELD    = 4'b0100;
  localparam logic [3:0]  HELDERR = 4'b0101;
  localparam logic [3:0]  RUNNING = 4'b1010;

  logic        clk = 1'b0;
  logic        rstN;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [31:0] romAddress;
  logic [31:0] romData;
  logic        cpuEnable;
  logic        cpuReset;
  logic        loaded;
  logic        error;
  logic [15:0] wordCount;

  always #5 clk = ~clk;

  boot_loader dut (
    .clk         (clk),
    .rst         (rstN),
    .rx_data     (rxData),
    .rx_valid    (rxValid),
    .rom_address (romAddress),
    .rom_data    (romData),
    .cpu_enable  (cpuEnable),
    .cpu_reset   (cpuReset),
    .loaded      (loaded),
    .error       (error),
    .word_count  (wordCount)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [31:0] a;
    logic [3:0]  flags;
    logic [15:0] wc;
    logic [31:0] rd;
  } vecT;

  vecT vecs[$];
  int  passCount  = 0;
  int  checkCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkOutputs(input string tag, input logic [3:0] flags, input logic [15:0] wc,
                              input logic [31:0] rd);
    check({tag, " cpu_enable"}, 32'(cpuEnable), 32'(flags[3]));
    check({tag, " cpu_reset"},  32'(cpuReset),  32'(flags[2]));
    check({tag, " loaded"},     32'(loaded),    32'(flags[1]));
    check({tag, " error"},      32'(error),     32'(flags[0]));
    check({tag, " word_count"}, 32'(wordCount), 32'(wc));
    check({tag, " rom_data"},   romData,        rd);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [31:0] a, input logic [3:0] flags,
                     input logic [15:0] wc, input logic [31:0] rd);
    vecT t;
    t.v = v; t.d = d; t.a = a; t.flags = flags; t.wc = wc; t.rd = rd;
    vecs.push_back(t);
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rxValid = 1'b1;
    rxData  = b;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  imgA [12];
    logic [7:0]  imgB [8];
    logic [7:0]  badLen [9];
    logic [31:0] full [256];
    logic [31:0] w;
    logic [7:0]  csum;

    imgA   = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    imgB   = '{8'hA5, 8'h01, 8'h00, 8'h37, 8'h05, 8'h00, 8'h00, 8'h32};
    badLen = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h01, 8'h01, 8'hA5, 8'h01, 8'h02};

    // bytes ignored in IDLE
    add(1'b1, 8'h00, 32'h0, HELD, 16'd0, NOP);
    add(1'b1, 8'hFF, 32'h0, HELD, 16'd0, NOP);
    add(1'b1, 8'h13, 32'h0, HELD, 16'd0, NOP);
    // two-word image, back-to-back bytes
    for (int i = 0; i < 11; i++) add(1'b1, imgA[i], 32'h0, HELD, 16'd0, NOP);
    add(1'b1, imgA[11], 32'h0, RUNNING, 16'd2, 32'h0050_0093);
    add(1'b0, 8'h00, 32'h4,   RUNNING, 16'd2, 32'h00A0_0113);
    add(1'b0, 8'h00, 32'h8,   RUNNING, 16'd2, NOP);
    add(1'b0, 8'h00, 32'h400, RUNNING, 16'd2, NOP);
    add(1'b0, 8'h00, 32'h6,   RUNNING, 16'd2, 32'h00A0_0113);
    add(1'b1, 8'h13, 32'h3,   RUNNING, 16'd2, 32'h0050_0093);
    // reload from RUN with a one-word image
    for (int i = 0; i < 7; i++) add(1'b1, imgB[i], 32'h0, HELD, 16'd2, NOP);
    add(1'b1, imgB[7], 32'h0, RUNNING, 16'd1, 32'h0000_0537);
    add(1'b0, 8'h00,   32'h4, RUNNING, 16'd1, NOP);
    // bad checksum
    for (int i = 0; i < 11; i++) add(1'b1, imgA[i], 32'h0, HELD, 16'd1, NOP);
    add(1'b1, 8'h58, 32'h0, HELDERR, 16'd0, NOP);
    add(1'b1, 8'h00, 32'h0, HELDERR, 16'd0, NOP);
    // N=0, N=257, N=513 all rejected right after LEN_HI
    for (int i = 0; i < 9; i++) add(1'b1, badLen[i], 32'h0, HELDERR, 16'd0, NOP);
    add(1'b1, 8'h37, 32'h0, HELDERR, 16'd0, NOP);
    // a good image clears error
    for (int i = 0; i < 7; i++) add(1'b1, imgB[i], 32'h0, HELDERR, 16'd0, NOP);
    add(1'b1, imgB[7], 32'h0, RUNNING, 16'd1, 32'h0000_0537);

    rstN = 1'b0; rxValid = 1'b0; rxData = 8'h00; romAddress = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutputs("reset", HELD, 16'd0, NOP);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rxValid    = vecs[i].v;
      rxData     = vecs[i].d;
      romAddress = vecs[i].a;
      @(posedge clk);
      #1;
      checkOutputs($sformatf("vec%0d", i), vecs[i].flags, vecs[i].wc, vecs[i].rd);
    end
    @(negedge clk);
    rxValid    = 1'b0;
    romAddress = 32'h0;

    // full-depth image (N = DEPTH_WORDS)
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    csum = 8'h00;
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
      full[i] = w;
      for (int k = 0; k < 4; k++) begin
        csum ^= w[8*k +: 8];
        sendByte(w[8*k +: 8]);
      end
    end
    check("full pre-checksum loaded", 32'(loaded), 32'd0);
    sendByte(csum);
    checkOutputs("full", RUNNING, 16'd256, full[0]);
    romAddress = 32'h3FC; #1;
    check("full last word", romData, full[255]);
    romAddress = 32'h201; #1;
    check("full mid word", romData, full[128]);
    romAddress = 32'h400; #1;
    check("full beyond depth", romData, NOP);
    romAddress = 32'h0;

    // from RUN into ERROR via N=0, then abort a load with reset
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
    check("n0 from run error", 32'(error), 32'd1);
    check("n0 from run loaded", 32'(loaded), 32'd0);
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44); sendByte(8'h55);
    #2;
    rstN = 1'b0;
    #1;
    checkOutputs("midreset", HELD, 16'd0, NOP);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 12; i++) sendByte(imgA[i]);
    checkOutputs("after reset", RUNNING, 16'd2, 32'h0050_0093);
    romAddress = 32'h4; #1;
    check("after reset word1", romData, 32'h00A0_0113);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
